button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/flappy_pkg.sv | 28 ++
 rtl/button_conditioner_if.sv | 12 +
 rtl/btn_channel.sv | 152 +++++++++++++++
 rtl/button_conditioner.sv | 52 +++++
 tb/tb_button_conditioner.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy-bird push-button front end:
// per-channel state encoding and the default timing constants.
package flappy_pkg;

    typedef enum logic [2:0] {
        RELEASED,
        PRESS_CHK,
        HELD_DELAY,
        HELD_REPEAT,
        RELEASE_CHK
    } btn_state_e;

    localparam int DEF_NUM_BTN         = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 5000000;
    localparam int DEF_REPEAT_PERIOD   = 2500000;

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pins and the game logic.
interface button_conditioner_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic               btn_conflict;

    modport master (output btn_raw, input btn_level, input btn_press, input btn_conflict);
    modport slave  (input btn_raw, output btn_level, output btn_press, output btn_conflict);
endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce/auto-repeat FSM and
// a saturating counter pair (debounce count, repeat count).
module btn_channel
    import flappy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    input  logic i_suppress,
    output logic o_level,
    output logic o_press,
    output logic o_level_nxt
);
    localparam int DB   = at_least_one(DEBOUNCE_CYCLES);
    localparam int RD   = at_least_one(REPEAT_DELAY);
    localparam int RP   = at_least_one(REPEAT_PERIOD);
    localparam int MAXC = max3(DB, RD, RP);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    // Counters act on the "next" sample: a stored value of LIMIT-1 means the
    // current sample completes the count, so stored values stay below MAXC.
    localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(RD - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(RP - 1);

    logic [1:0]    r_sync;
    btn_state_e    r_state;
    logic [CW-1:0] r_dcnt;
    logic [CW-1:0] r_rcnt;
    logic          r_prior_rep;
    logic          r_level;
    logic          r_press;

    btn_state_e    w_state_nxt;
    logic [CW-1:0] w_dcnt_nxt;
    logic [CW-1:0] w_rcnt_nxt;
    logic          w_prior_nxt;
    logic          w_level_nxt;
    logic          w_press_nxt;
    logic          w_sync;
    logic [CW-1:0] w_dcnt_inc;
    logic [CW-1:0] w_rcnt_inc;
    logic [CW-1:0] w_rep_last;

    assign w_sync     = r_sync[1];
    assign w_dcnt_inc = (&r_dcnt) ? r_dcnt : r_dcnt + 1'b1;
    assign w_rcnt_inc = (&r_rcnt) ? r_rcnt : r_rcnt + 1'b1;
    assign w_rep_last = (r_state == HELD_DELAY) ? RD_LAST : RP_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync      <= '0;
            r_state     <= RELEASED;
            r_dcnt      <= '0;
            r_rcnt      <= '0;
            r_prior_rep <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], i_raw};
            r_state     <= w_state_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_rcnt      <= w_rcnt_nxt;
            r_prior_rep <= w_prior_nxt;
            r_level     <= w_level_nxt;
            r_press     <= w_press_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_rcnt_nxt  = r_rcnt;
        w_prior_nxt = r_prior_rep;
        w_level_nxt = r_level;
        w_press_nxt = 1'b0;
        case (r_state)
            RELEASED: begin
                if (w_sync) begin
                    if (DB_LAST == '0) begin
                        w_state_nxt = HELD_DELAY;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = PRESS_CHK;
                        w_dcnt_nxt  = CW'(1);
                    end
                end
            end
            PRESS_CHK: begin
                if (!w_sync) begin
                    w_state_nxt = RELEASED;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt >= DB_LAST) begin
                    w_state_nxt = HELD_DELAY;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                    w_dcnt_nxt  = '0;
                    w_rcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt  = w_dcnt_inc;
                end
            end
            HELD_DELAY, HELD_REPEAT: begin
                if (!w_sync) begin
                    w_prior_nxt = (r_state == HELD_REPEAT);
                    if (DB_LAST == '0) begin
                        w_state_nxt = RELEASED;
                        w_level_nxt = 1'b0;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = RELEASE_CHK;
                        w_dcnt_nxt  = CW'(1);
                    end
                end else if (!i_suppress) begin
                    if (r_rcnt >= w_rep_last) begin
                        w_state_nxt = HELD_REPEAT;
                        w_press_nxt = 1'b1;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_rcnt_nxt  = w_rcnt_inc;
                    end
                end
            end
            RELEASE_CHK: begin
                // Repeat counter is left alone so a bounce resumes the cadence.
                if (w_sync) begin
                    w_state_nxt = r_prior_rep ? HELD_REPEAT : HELD_DELAY;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt >= DB_LAST) begin
                    w_state_nxt = RELEASED;
                    w_level_nxt = 1'b0;
                    w_dcnt_nxt  = '0;
                    w_rcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt  = w_dcnt_inc;
                end
            end
            default: w_state_nxt = RELEASED;
        endcase
    end

    assign o_level     = r_level;
    assign o_press     = r_press;
    assign o_level_nxt = w_level_nxt;

endmodule

// File: rtl/button_conditioner.sv
// Debounce + auto-repeat front end for the game buttons, with up/down
// conflict detection that freezes auto-repeat while both are held.
module button_conditioner
    import flappy_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btn
);
    logic [NUM_BTN-1:0] w_level_nxt;
    logic [NUM_BTN-1:0] w_suppress;
    logic               r_conflict;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .i_raw       (btn.btn_raw[g]),
            .i_suppress  (w_suppress[g]),
            .o_level     (btn.btn_level[g]),
            .o_press     (btn.btn_press[g]),
            .o_level_nxt (w_level_nxt[g])
        );
    end

    // Built from next-state levels so the flag lines up with btn_level.
    if (NUM_BTN >= 2) begin : g_conflict
        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_conflict <= 1'b0;
            else       r_conflict <= w_level_nxt[0] & w_level_nxt[1];
        end
        always_comb begin
            w_suppress      = '0;
            w_suppress[1:0] = {2{r_conflict}};
        end
    end else begin : g_no_conflict
        assign r_conflict = 1'b0;
        assign w_suppress = '0;
    end

    assign btn.btn_conflict = r_conflict;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed + randomized bench for button_conditioner against a run-length
// reference model of debounce, auto-repeat and conflict suppression.
module tb_button_conditioner;
    localparam int NB = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    button_conditioner_if #(.NUM_BTN(NB)) bus ();

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bus)
    );

    always #5 clk = ~clk;

    // Reference state: sample delay line, accepted level, length of the current
    // run of samples disagreeing with the level, and held-cycle count since press.
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_press;
    logic          m_conf;
    int            m_run [NB];
    int            m_k   [NB];
    int            q0[$];
    int            q1[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_conf = 1'b0;
        for (int c = 0; c < NB; c++) begin
            m_run[c] = 0;
            m_k[c]   = 0;
        end
    endtask

    task automatic model_edge();
        logic [NB-1:0] smp;
        logic          conf_b;
        logic          pend;
        smp    = m_s2;
        m_s2   = m_s1;
        m_s1   = bus.btn_raw;
        conf_b = m_lvl[0] & m_lvl[1];
        m_press = '0;
        for (int c = 0; c < NB; c++) begin
            pend = (m_run[c] != 0);
            if (smp[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] >= DB) begin
                    m_lvl[c] = smp[c];
                    m_run[c] = 0;
                    if (smp[c]) begin
                        m_press[c] = 1'b1;
                        m_k[c]     = 0;
                    end
                end
            end else begin
                if (m_lvl[c] && !pend && !(c < 2 && conf_b)) begin
                    m_k[c]++;
                    if (m_k[c] == RD || (m_k[c] > RD && (m_k[c] - RD) % RP == 0))
                        m_press[c] = 1'b1;
                end
                m_run[c] = 0;
            end
        end
        m_conf = m_lvl[0] & m_lvl[1];
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("level", 32'(bus.btn_level), 32'(m_lvl));
        chk("press", 32'(bus.btn_press), 32'(m_press));
        chk("conflict", 32'(bus.btn_conflict), 32'(m_conf));
        if (bus.btn_press[0]) q0.push_back(cyc);
        if (bus.btn_press[1]) q1.push_back(cyc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_level", 32'(bus.btn_level), 0);
        chk("rst_press", 32'(bus.btn_press), 0);
        chk("rst_conflict", 32'(bus.btn_conflict), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        int            e;
        logic          ok;
        logic [NB-1:0] seen;
        int            hold [NB];

        bus.btn_raw = '0;
        model_reset();
        #1;
        chk("init_level", 32'(bus.btn_level), 0);
        chk("init_press", 32'(bus.btn_press), 0);
        chk("init_conflict", 32'(bus.btn_conflict), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        run(3);

        // Single press, held: latency and repeat cadence.
        q0.delete(); e = cyc; bus.btn_raw = 2'b01;
        run(25);
        if (q0.size() >= 4) begin
            chk("press_latency", q0[0] - e, 6);
            chk("repeat1", q0[1] - q0[0], 10);
            chk("repeat2", q0[2] - q0[0], 13);
            chk("repeat3", q0[3] - q0[0], 16);
        end else chk("press_count", q0.size(), 4);

        // Short release bounce while held: level holds, cadence resumes.
        e = q0[q0.size()-1]; q0.delete(); ok = 1'b1;
        bus.btn_raw[0] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) bus.btn_raw[0] = 1'b1;
            step();
            ok &= bus.btn_level[0];
        end
        chk("bounce_level", 32'(ok), 1);
        if (q0.size() >= 2) begin
            chk("bounce_resume", q0[0] - e, 7);
            chk("bounce_period", q0[1] - q0[0], 3);
        end else chk("bounce_count", q0.size(), 2);
        bus.btn_raw = '0;
        run(10);

        // Glitch on channel 1 shorter than the debounce window.
        seen = '0; bus.btn_raw[1] = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) bus.btn_raw[1] = 1'b0;
            step();
            seen[0] = seen[0] | bus.btn_level[1];
            seen[1] = seen[1] | bus.btn_press[1];
        end
        chk("glitch_rejected", 32'(seen), 0);

        // Both held: coincident presses, conflict, no repeats until down releases.
        q0.delete(); q1.delete(); bus.btn_raw = 2'b11;
        run(40);
        chk("both_conflict", 32'(bus.btn_conflict), 1);
        chk("both_presses", q0.size() * 10 + q1.size(), 11);
        if (q0.size() > 0 && q1.size() > 0) chk("both_same_cycle", q0[0], q1[0]);
        q0.delete(); e = cyc; bus.btn_raw[1] = 1'b0;
        run(30);
        if (q0.size() > 0) chk("resume_after_conflict", q0[0] - e, 16);
        else chk("resume_count", q0.size(), 1);
        bus.btn_raw = '0;
        run(10);

        // Reset mid-repeat with the button still held.
        bus.btn_raw = 2'b01;
        run(25);
        do_reset();
        q0.delete(); e = cyc;
        run(8);
        if (q0.size() > 0) chk("reset_relatency", q0[0] - e, 6);
        else chk("reset_press_count", q0.size(), 1);
        bus.btn_raw = '0;
        run(10);

        // Random bouncing/holding on both channels with rare resets.
        for (int c = 0; c < NB; c++) hold[c] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NB; c++) begin
                if (hold[c] == 0) begin
                    bus.btn_raw[c] = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(5, 45));
                end else hold[c]--;
            end
            if ($urandom_range(0, 999) == 0) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
